// File: rtl/cpu_hazard_pkg.sv
// Shared hazard-controller types: FSM state encoding, flush-length limits, counter widths.
package cpu_hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  localparam int unsigned FLUSH_CYCLES_MIN = 1;
  localparam int unsigned FLUSH_CYCLES_MAX = 4;
  localparam int unsigned CNT_W            = $clog2(FLUSH_CYCLES_MAX);
  localparam int unsigned STAT_W           = 32;

endpackage

// File: rtl/cpu_hazard_stats.sv
// Free-running hazard statistics counters (stall cycles, taken-branch flushes, load-use bubbles).
module cpu_hazard_stats
  import cpu_hazard_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_ev,
  input  logic              flush_ev,
  input  logic              lu_ev,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events,
  output logic [STAT_W-1:0] load_use_events
);

  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [STAT_W-1:0] lu_cnt_q,    lu_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + STAT_W'(stall_ev);
    flush_cnt_d = flush_cnt_q + STAT_W'(flush_ev);
    lu_cnt_d    = lu_cnt_q    + STAT_W'(lu_ev);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign flush_events    = flush_cnt_q;
  assign load_use_events = lu_cnt_q;

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory miss freeze, taken-branch flush.
// Optional statistics counters are built when CPU_HAZARD_STATS_EN is defined.
module cpu_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] ra_id,
  input  logic [REG_W-1:0] rb_id,
  input  logic             ra_used_id,
  input  logic             rb_used_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             load_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             branch_taken_ex,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_ex,
  output logic             flush_if_id,
`ifdef CPU_HAZARD_STATS_EN
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events,
  output logic [STAT_W-1:0] load_use_events,
`endif
  output logic [1:0]       state
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic mem_stall_c, load_use_c;
  logic stall_all_c, stall_fe_c, bubble_c, flush_c;

  assign mem_stall_c = dmem_req && !dmem_ready;
  assign load_use_c  = load_ex && (rd_ex != '0) &&
                       ((ra_used_id && (ra_id == rd_ex)) || (rb_used_id && (rb_id == rd_ex)));

  // stall_fe_c holds only the front end (IF/ID); stall_all_c freezes every pipeline register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_all_c = 1'b0;
    stall_fe_c  = 1'b0;
    bubble_c    = 1'b0;
    flush_c     = 1'b0;
    if (reset) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_stall_c) begin
            stall_all_c = 1'b1;
            state_d     = ST_MEM_WAIT;
          end else if (branch_taken_ex) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
              state_d = ST_FLUSH;
            end
          end else if (load_use_c) begin
            stall_fe_c = 1'b1;
            bubble_c   = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_stall_c) begin
            stall_all_c = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_c = 1'b1;
          if (mem_stall_c) begin
            stall_all_c = 1'b1;
          end else begin
            cnt_d = CNT_W'(cnt_q - CNT_W'(1));
            if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign stall_if    = stall_all_c | stall_fe_c;
  assign stall_id    = stall_all_c | stall_fe_c;
  assign stall_ex    = stall_all_c;
  assign stall_mem   = stall_all_c;
  assign bubble_ex   = bubble_c;
  assign flush_if_id = flush_c;
  assign state       = state_q;

`ifdef CPU_HAZARD_STATS_EN
  // A front-end-only stall with a bubble is a load-use; a flush seen in RUN is an accepted branch.
  logic flush_ev_c, lu_ev_c;
  assign flush_ev_c = (state_q == ST_RUN) && flush_c;
  assign lu_ev_c    = stall_fe_c && bubble_c;

  cpu_hazard_stats u_stats (
    .clock           (clock),
    .reset           (reset),
    .stall_ev        (stall_if),
    .flush_ev        (flush_ev_c),
    .lu_ev           (lu_ev_c),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .load_use_events (load_use_events)
  );
`endif

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed self-checking bench for cpu_hazard_ctrl (FLUSH_CYCLES=3).
module tb_cpu_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ra_id, rb_id, rd_ex;
  logic       ra_used_id, rb_used_id, load_ex;
  logic       dmem_req, dmem_ready, branch_taken_ex;
  logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if_id;
  logic [1:0] state;
`ifdef CPU_HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_events, load_use_events;
`endif

  int compared   = 0;
  int mismatched = 0;
  int flush_cnt;
  int stall_cnt;

  always #5 clock = ~clock;

  cpu_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .ra_id           (ra_id),
    .rb_id           (rb_id),
    .ra_used_id      (ra_used_id),
    .rb_used_id      (rb_used_id),
    .rd_ex           (rd_ex),
    .load_ex         (load_ex),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .branch_taken_ex (branch_taken_ex),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .stall_mem       (stall_mem),
    .bubble_ex       (bubble_ex),
    .flush_if_id     (flush_if_id),
`ifdef CPU_HAZARD_STATS_EN
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events),
    .load_use_events (load_use_events),
`endif
    .state           (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if_id} plus state.
  task automatic chk_out(input string tag, input logic [5:0] exp_o, input logic [1:0] exp_s);
    chk({tag, ".outs"}, 32'({stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if_id}),
        32'(exp_o));
    chk({tag, ".state"}, 32'(state), 32'(exp_s));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    ra_id = '0; rb_id = '0; rd_ex = '0;
    ra_used_id = 1'b0; rb_used_id = 1'b0; load_ex = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; branch_taken_ex = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    dmem_req = 1'b1; branch_taken_ex = 1'b1;
    tick(); sample();
    chk_out("reset_hold", 6'b000000, 2'd0);
    reset = 1'b0; idle_inputs();
    tick(); sample();
    chk_out("idle", 6'b000000, 2'd0);

    // Load-use on ra, then cleared
    load_ex = 1'b1; rd_ex = 5'd3; ra_id = 5'd3; ra_used_id = 1'b1;
    sample(); chk_out("lu_ra", 6'b110010, 2'd0);
    tick(); load_ex = 1'b0;
    sample(); chk_out("lu_after", 6'b000000, 2'd0);

    // Suppressed load-use cases, then rb path
    tick(); load_ex = 1'b1; rd_ex = 5'd0; ra_id = 5'd0; ra_used_id = 1'b1;
    sample(); chk_out("lu_rd0", 6'b000000, 2'd0);
    tick(); rd_ex = 5'd3; ra_id = 5'd3; ra_used_id = 1'b0;
    sample(); chk_out("lu_unused", 6'b000000, 2'd0);
    tick(); rb_id = 5'd3; rb_used_id = 1'b1;
    sample(); chk_out("lu_rb", 6'b110010, 2'd0);
    tick(); idle_inputs();

    // 3-cycle miss then ack
    dmem_req = 1'b1; dmem_ready = 1'b0; stall_cnt = 0;
    sample(); chk_out("miss_c0", 6'b111100, 2'd0); stall_cnt += int'(stall_mem);
    tick(); sample(); chk_out("miss_c1", 6'b111100, 2'd1); stall_cnt += int'(stall_mem);
    tick(); sample(); chk_out("miss_c2", 6'b111100, 2'd1); stall_cnt += int'(stall_mem);
    tick(); dmem_ready = 1'b1;
    sample(); chk_out("miss_ack", 6'b000000, 2'd1); stall_cnt += int'(stall_mem);
    chk("miss_stall_total", 32'(stall_cnt), 32'd3);
    tick(); idle_inputs();
    sample(); chk_out("miss_done", 6'b000000, 2'd0);

    // Miss and taken branch together: stalls only, then flush after ack
    tick(); dmem_req = 1'b1; branch_taken_ex = 1'b1;
    sample(); chk_out("sim_c0", 6'b111100, 2'd0);
    tick(); sample(); chk_out("sim_wait", 6'b111100, 2'd1);
    tick(); dmem_ready = 1'b1;
    sample(); chk_out("sim_ack", 6'b000000, 2'd1);
    tick(); dmem_req = 1'b0; dmem_ready = 1'b0;
    sample(); chk_out("sim_br", 6'b000011, 2'd0);
    tick(); branch_taken_ex = 1'b0;
    sample(); chk_out("sim_fl1", 6'b000001, 2'd2);
    tick(); sample(); chk_out("sim_fl2", 6'b000001, 2'd2);
    tick(); sample(); chk_out("sim_end", 6'b000000, 2'd0);

    // Taken branch with a 2-cycle miss during FLUSH; load-use ignored in FLUSH
    tick(); branch_taken_ex = 1'b1; flush_cnt = 0;
    sample(); chk_out("fm_br", 6'b000011, 2'd0); flush_cnt += int'(flush_if_id);
    tick(); branch_taken_ex = 1'b0;
    load_ex = 1'b1; rd_ex = 5'd7; ra_id = 5'd7; ra_used_id = 1'b1;
    sample(); chk_out("fm_fl_lu", 6'b000001, 2'd2); flush_cnt += int'(flush_if_id);
    tick(); idle_inputs(); dmem_req = 1'b1;
    sample(); chk_out("fm_miss1", 6'b111101, 2'd2); flush_cnt += int'(flush_if_id);
    tick(); sample(); chk_out("fm_miss2", 6'b111101, 2'd2); flush_cnt += int'(flush_if_id);
    tick(); dmem_req = 1'b0;
    sample(); chk_out("fm_last", 6'b000001, 2'd2); flush_cnt += int'(flush_if_id);
    tick(); sample(); chk_out("fm_end", 6'b000000, 2'd0); flush_cnt += int'(flush_if_id);
    chk("fm_flush_total", 32'(flush_cnt), 32'd5);

    // Reset while in MEM_WAIT
    tick(); dmem_req = 1'b1;
    tick(); sample(); chk_out("rst_pre", 6'b111100, 2'd1);
    tick(); reset = 1'b1;
    sample(); chk_out("rst_now", 6'b000000, 2'd1);
    tick(); sample(); chk_out("rst_next", 6'b000000, 2'd0);
`ifdef CPU_HAZARD_STATS_EN
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_flush_events", flush_events, 32'd0);
    chk("rst_lu_events", load_use_events, 32'd0);
`endif
    reset = 1'b0; idle_inputs();
    tick(); sample(); chk_out("post_rst", 6'b000000, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
